// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Requester-side bus for the shared UART transmitter. The requesters drive
// valid and data. The arbiter returns a one-hot accept pulse, the index of
// the current or last grant, and a busy flag.
//
//   req_valid  NREQ          bit i: requester i has a byte pending
//   req_data   NREQ*DATA_W   byte of requester i at [i*DATA_W +: DATA_W]
//   req_ready  NREQ          one-hot, single-cycle accept pulse
//   grant_id   GID_W         index of the current/last granted requester
//   busy       1             high from grant until the end of the stop bit
//
// master: requester side, slave: arbiter side.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8,
    parameter int GID_W  = 2
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic [GID_W-1:0]       grant_id;
    logic                   busy;

    modport master (
        output req_valid, req_data,
        input  req_ready, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one serial transmit line between NREQ requesters. A round-robin
// arbiter picks one pending byte and latches it. The byte is then sent
// LSB-first as an 8N1 frame, with bit timing paced by rising edges of the
// baud clock bclk (one bclk period per bit).
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous, active-high reset
//   bclk  in   baud clock; a rising edge marks a bit boundary
//   bus   slave modport of uart_tx_arbiter_if (req_valid, req_data,
//              req_ready, grant_id, busy)
//   tx    out  serial line, idle high
//
// Build option:
//   UART_TX_PARITY_EN  adds an even-parity bit between D7 and the stop bit.
//                      The frame becomes 8E1 (11 bclk periods).
//
// States:
//   state    | meaning
//   ---------+----------------------------------------------------
//   S_IDLE   | line high, arbitrate among pending requesters
//   S_ARM    | byte latched, waiting for a bit boundary to start
//   S_START  | start bit (0) on the line
//   S_DATA   | data bits D0..D7 on the line
//   S_PARITY | even parity bit on the line (parity build only)
//   S_STOP   | stop bit (1) on the line; busy drops at its end
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8,
    parameter int GID_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bclk,
    uart_tx_arbiter_if.slave        bus,
    output logic                    tx
);

    localparam int               CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [GID_W-1:0] LAST_INIT = GID_W'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic               bclk_q, bclk_d;
    logic               bedge;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [GID_W-1:0]   last_q, last_d;
    logic [GID_W-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]    ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    logic               arb_found;
    logic [GID_W-1:0]   arb_idx;
    logic [GID_W-1:0]   cand;
    logic [DATA_W-1:0]  arb_data;

    assign bclk_d = bclk;
    assign bedge  = bclk & ~bclk_q;

    // Round-robin scan starting just after the last grant. Walking the
    // offsets from farthest to nearest lets the nearest valid requester
    // win by overwriting the earlier hits.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = GID_W'((int'(last_q) + k) % NREQ);
            if (bus.req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        arb_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == GID_W'(i)) begin
                arb_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register: all flops of the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            bclk_q   <= 1'b1;
            shift_q  <= '0;
            bitcnt_q <= '0;
            last_q   <= LAST_INIT;
            grant_q  <= '0;
            ready_q  <= '0;
            busy_q   <= 1'b0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            bclk_q   <= bclk_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (arb_found) state_d = S_ARM;
            S_ARM:    if (bedge) state_d = S_START;
            S_START:  if (bedge) state_d = S_DATA;
            S_DATA: begin
                if (bedge && (bitcnt_q == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bedge) state_d = S_STOP;
`endif
            S_STOP:   if (bedge) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs. Without a bclk edge, every register
    // holds its value, so a stalled baud clock freezes the line.
    always_comb begin
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        last_d   = last_q;
        grant_d  = grant_q;
        ready_d  = '0;
        busy_d   = busy_q;
        tx_d     = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (arb_found) begin
                    shift_d = arb_data;
                    grant_d = arb_idx;
                    last_d  = arb_idx;
                    ready_d = NREQ'(1) << arb_idx;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^arb_data;
`endif
                end
            end
            S_ARM: begin
                if (bedge) tx_d = 1'b0;
            end
            S_START: begin
                if (bedge) begin
                    tx_d     = shift_q[0];
                    shift_d  = shift_q >> 1;
                    bitcnt_d = '0;
                end
            end
            S_DATA: begin
                if (bedge) begin
                    if (bitcnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        tx_d = par_q;
`else
                        tx_d = 1'b1;
`endif
                    end else begin
                        tx_d     = shift_q[0];
                        shift_d  = shift_q >> 1;
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bedge) tx_d = 1'b1;
            end
`endif
            S_STOP: begin
                if (bedge) busy_d = 1'b0;
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

    assign bus.req_ready = ready_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = busy_q;
    assign tx            = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
    localparam int NREQ     = 4;
    localparam int DATA_W   = 8;
    localparam int GID_W    = 2;
    localparam int BIT_CLKS = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic clk, rst, bclk, tx;
    bit   bclk_run = 1'b1;

    uart_tx_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .GID_W(GID_W)) bus();

    uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .GID_W(GID_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bclk (bclk),
        .bus  (bus.slave),
        .tx   (tx)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]       pend [NREQ][$];
    logic [NREQ-1:0]  extra_valid = '0;
    logic [NREQ-1:0]  rlog [$];
    logic [GID_W-1:0] glog [$];

    typedef struct {
        logic [7:0] data;
        logic       start;
        logic       par;
        logic       stop;
    } rx_t;
    rx_t rx_log [$];
    bit  rx_busy = 1'b0;

    int         exp_gid [$];
    logic [7:0] exp_dat [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud clock: 16 clk periods, edges offset from clk edges.
    initial begin
        bclk = 1'b1;
        #3;
        forever begin
            #80;
            if (bclk_run) bclk = ~bclk;
        end
    end

    // Requester model: each requester presents the head of its queue and
    // pops it on the accept pulse. Accepts are logged for the checks.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.req_ready != '0) begin
                rlog.push_back(bus.req_ready);
                glog.push_back(bus.grant_id);
                for (int i = 0; i < NREQ; i++)
                    if (bus.req_ready[i] && pend[i].size() != 0) void'(pend[i].pop_front());
            end
            for (int i = 0; i < NREQ; i++) begin
                bus.req_valid[i] = (pend[i].size() != 0) || extra_valid[i];
                bus.req_data[i*DATA_W +: DATA_W] = (pend[i].size() != 0) ? pend[i][0] : 8'h00;
            end
        end
    end

    // Line receiver: finds a falling edge and samples each bit mid-period.
    initial begin
        logic prev;
        rx_t  r;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev === 1'b1 && tx === 1'b0) begin
                rx_busy = 1'b1;
                repeat (BIT_CLKS/2) @(negedge clk);
                r.start = tx;
                for (int j = 0; j < 8; j++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    r.data[j] = tx;
                end
                r.par = 1'b0;
`ifdef UART_TX_PARITY_EN
                repeat (BIT_CLKS) @(negedge clk);
                r.par = tx;
`endif
                repeat (BIT_CLKS) @(negedge clk);
                r.stop = tx;
                rx_log.push_back(r);
                rx_busy = 1'b0;
            end
            prev = tx;
        end
    end

    // Expected value of bit b of a frame carrying byte d.
    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Round-robin reference: from the pending queues, starting with the
    // pointer at NREQ-1, list who is served in which order and with which byte.
    task automatic build_expected();
        logic [7:0] mq [NREQ][$];
        int last;
        int pick;
        exp_gid.delete();
        exp_dat.delete();
        for (int i = 0; i < NREQ; i++) mq[i] = pend[i];
        last = NREQ - 1;
        do begin
            pick = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (last + k) % NREQ;
                if (pick < 0 && mq[c].size() != 0) pick = c;
            end
            if (pick >= 0) begin
                exp_gid.push_back(pick);
                exp_dat.push_back(mq[pick].pop_front());
                last = pick;
            end
        end while (pick >= 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        extra_valid = '0;
        for (int i = 0; i < NREQ; i++) pend[i].delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rlog.delete();
        glog.delete();
        rx_log.delete();
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        bit any;
        ok = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            any = 1'b0;
            for (int i = 0; i < NREQ; i++) if (pend[i].size() != 0) any = 1'b1;
            if (!any && bus.busy === 1'b0 && !rx_busy && n > 2) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.req_ready !== '0) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
        n_cmp++; if (bus.grant_id !== '0) begin n_bad++; $display("FAIL reset_grant: got %0d want 0", bus.grant_id); end
        bad = 0;
        repeat (48) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.busy !== 1'b0 || bus.req_ready !== '0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL idle_quiet: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_single();
        int k = -1, c_r = -1, pulses = 0, idx;
        logic [NREQ-1:0] rdy = '0;
        logic want;
        bit done = 1'b0;
        bit ok;
        do_reset();
        pend[0].push_back(8'h55);
        for (int c = 0; c < 600 && !done; c++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                pulses++;
                rdy = bus.req_ready;
                if (c_r < 0) c_r = c;
            end
            if (k < 0 && tx === 1'b0) k = c;
            if (k >= 0) begin
                idx = c - k;
                if (idx < FRAME_BITS*BIT_CLKS) begin
                    want = frame_bit(8'h55, idx / BIT_CLKS);
                    n_cmp++;
                    if (tx !== want) begin n_bad++; $display("FAIL single_tx: offset %0d bit %0d got %b want %b", idx, idx / BIT_CLKS, tx, want); end
                    if (idx == FRAME_BITS*BIT_CLKS - 1) begin
                        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_stop: got %b want 1", bus.busy); end
                    end
                end else begin
                    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_fall: got %b want 0", bus.busy); end
                    done = 1'b1;
                end
            end
        end
        n_cmp++; if (!done) begin n_bad++; $display("FAIL single_timeout: frame end seen %b want 1", done); end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL single_ready_count: got %0d want 1", pulses); end
        n_cmp++; if (rdy !== 4'b0001) begin n_bad++; $display("FAIL single_ready_vec: got %b want 0001", rdy); end
        n_cmp++; if (c_r < 0 || (k - c_r) < 1 || (k - c_r) > BIT_CLKS) begin n_bad++; $display("FAIL single_start_latency: got %0d want 1..%0d", k - c_r, BIT_CLKS); end
        wait_drain(200, ok);
    endtask

    task automatic test_all_four();
        bit ok;
        do_reset();
        for (int i = 0; i < NREQ; i++) pend[i].push_back(8'(8'hA0 + i));
        wait_drain(4000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL all4_timeout: drained %b want 1", ok); end
        n_cmp++; if (rlog.size() != 4) begin n_bad++; $display("FAIL all4_ready_count: got %0d want 4", rlog.size()); end
        n_cmp++; if (rx_log.size() != 4) begin n_bad++; $display("FAIL all4_frame_count: got %0d want 4", rx_log.size()); end
        for (int j = 0; j < 4; j++) begin
            if (j < rlog.size()) begin
                n_cmp++; if (rlog[j] !== 4'(1 << j)) begin n_bad++; $display("FAIL all4_ready[%0d]: got %b want %b", j, rlog[j], 4'(1 << j)); end
                n_cmp++; if (glog[j] !== GID_W'(j)) begin n_bad++; $display("FAIL all4_grant[%0d]: got %0d want %0d", j, glog[j], j); end
            end
            if (j < rx_log.size()) begin
                n_cmp++; if (rx_log[j].data !== 8'(8'hA0 + j)) begin n_bad++; $display("FAIL all4_data[%0d]: got %h want %h", j, rx_log[j].data, 8'(8'hA0 + j)); end
                n_cmp++; if (rx_log[j].start !== 1'b0 || rx_log[j].stop !== 1'b1) begin n_bad++; $display("FAIL all4_framing[%0d]: start %b stop %b want 0 1", j, rx_log[j].start, rx_log[j].stop); end
            end
        end
    endtask

    task automatic test_fairness();
        bit ok;
        logic [7:0] b0 [3];
        logic [7:0] b2 [3];
        do_reset();
        for (int j = 0; j < 3; j++) begin
            b0[j] = 8'($urandom);
            b2[j] = 8'($urandom);
            pend[0].push_back(b0[j]);
            pend[2].push_back(b2[j]);
        end
        wait_drain(6000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL fair_timeout: drained %b want 1", ok); end
        n_cmp++; if (glog.size() != 6) begin n_bad++; $display("FAIL fair_count: got %0d want 6", glog.size()); end
        for (int j = 0; j < 6; j++) begin
            if (j < glog.size()) begin
                n_cmp++; if (glog[j] !== GID_W'((j % 2) * 2)) begin n_bad++; $display("FAIL fair_grant[%0d]: got %0d want %0d", j, glog[j], (j % 2) * 2); end
            end
            if (j < rx_log.size()) begin
                n_cmp++; if (rx_log[j].data !== ((j % 2 == 0) ? b0[j/2] : b2[j/2])) begin n_bad++; $display("FAIL fair_data[%0d]: got %h want %h", j, rx_log[j].data, (j % 2 == 0) ? b0[j/2] : b2[j/2]); end
            end
        end
    endtask

    task automatic test_withdraw();
        bit ok;
        int bad;
        bit seen = 1'b0;
        do_reset();
        pend[0].push_back(8'h3C);
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL wd_busy_timeout: busy seen %b want 1", seen); end
        repeat (40) @(negedge clk);
        extra_valid[1] = 1'b1;
        repeat (60) @(negedge clk);
        extra_valid[1] = 1'b0;
        wait_drain(400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL wd_timeout: drained %b want 1", ok); end
        bad = 0;
        repeat (64) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL wd_idle_after: got %0d active cycles want 0", bad); end
        n_cmp++; if (rlog.size() != 1) begin n_bad++; $display("FAIL wd_ready_count: got %0d want 1", rlog.size()); end
        if (rlog.size() >= 1) begin
            n_cmp++; if (rlog[0] !== 4'b0001) begin n_bad++; $display("FAIL wd_ready_vec: got %b want 0001", rlog[0]); end
        end
        if (rx_log.size() >= 1) begin
            n_cmp++; if (rx_log[0].data !== 8'h3C) begin n_bad++; $display("FAIL wd_data: got %h want 3c", rx_log[0].data); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen = 1'b0;
        do_reset();
        pend[0].push_back(8'hFF);
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (tx === 1'b0) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL rm_start_timeout: start seen %b want 1", seen); end
        // Middle of D3: start bit plus D0..D2 plus half a bit after the fall.
        repeat (4*BIT_CLKS + BIT_CLKS/2) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rm_busy_mid: got %b want 1", bus.busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL rm_tx: got %b want 1", tx); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.req_ready !== '0) begin n_bad++; $display("FAIL rm_ready: got %b want 0000", bus.req_ready); end
        rlog.delete();
        glog.delete();
        repeat (200) @(negedge clk);
        n_cmp++; if (rlog.size() != 0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rm_no_retx: readies %0d busy %b want 0 0", rlog.size(), bus.busy); end
        rx_log.delete();
        pend[3].push_back(8'h5A);
        pend[0].push_back(8'hC3);
        wait_drain(1000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rm_timeout: drained %b want 1", ok); end
        n_cmp++; if (glog.size() != 2) begin n_bad++; $display("FAIL rm_count: got %0d want 2", glog.size()); end
        if (glog.size() == 2) begin
            n_cmp++; if (glog[0] !== 2'd0 || glog[1] !== 2'd3) begin n_bad++; $display("FAIL rm_order: got %0d,%0d want 0,3", glog[0], glog[1]); end
        end
        if (rx_log.size() >= 2) begin
            n_cmp++; if (rx_log[0].data !== 8'hC3 || rx_log[1].data !== 8'h5A) begin n_bad++; $display("FAIL rm_data: got %h,%h want c3,5a", rx_log[0].data, rx_log[1].data); end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        bit ok;
        do_reset();
        pend[0].push_back(8'h07);
        wait_drain(400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL par_timeout: drained %b want 1", ok); end
        n_cmp++; if (rx_log.size() != 1) begin n_bad++; $display("FAIL par_count: got %0d want 1", rx_log.size()); end
        if (rx_log.size() >= 1) begin
            n_cmp++; if (rx_log[0].data !== 8'h07) begin n_bad++; $display("FAIL par_data: got %h want 07", rx_log[0].data); end
            n_cmp++; if (rx_log[0].par !== 1'b1) begin n_bad++; $display("FAIL par_bit: got %b want 1", rx_log[0].par); end
            n_cmp++; if (rx_log[0].stop !== 1'b1) begin n_bad++; $display("FAIL par_stop: got %b want 1", rx_log[0].stop); end
        end
    endtask
`endif

    task automatic test_random();
        bit ok;
        int total;
        for (int round = 0; round < 3; round++) begin
            do_reset();
            total = 0;
            for (int i = 0; i < NREQ; i++) begin
                int n;
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) pend[i].push_back(8'($urandom));
                total += n;
            end
            if (total == 0) pend[$urandom_range(0, NREQ-1)].push_back(8'($urandom));
            build_expected();
            wait_drain(4000, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand%0d_timeout: drained %b want 1", round, ok); end
            n_cmp++; if (glog.size() != exp_gid.size()) begin n_bad++; $display("FAIL rand%0d_count: got %0d want %0d", round, glog.size(), exp_gid.size()); end
            n_cmp++; if (rx_log.size() != exp_dat.size()) begin n_bad++; $display("FAIL rand%0d_frames: got %0d want %0d", round, rx_log.size(), exp_dat.size()); end
            for (int j = 0; j < exp_gid.size(); j++) begin
                if (j < glog.size()) begin
                    n_cmp++; if (glog[j] !== GID_W'(exp_gid[j]) || rlog[j] !== 4'(1 << exp_gid[j])) begin n_bad++; $display("FAIL rand%0d_grant[%0d]: got id %0d ready %b want %0d", round, j, glog[j], rlog[j], exp_gid[j]); end
                end
                if (j < rx_log.size()) begin
                    n_cmp++; if (rx_log[j].data !== exp_dat[j] || rx_log[j].stop !== 1'b1) begin n_bad++; $display("FAIL rand%0d_data[%0d]: got %h stop %b want %h stop 1", round, j, rx_log[j].data, rx_log[j].stop, exp_dat[j]); end
                end
            end
        end
    endtask

    task automatic test_bclk_stuck();
        bit ok;
        bit seen = 1'b0;
        int changes = 0;
        logic v;
        do_reset();
        pend[0].push_back(8'h5A);
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (tx === 1'b0) seen = 1'b1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL stuck_start_timeout: start seen %b want 1", seen); end
        repeat (40) @(negedge clk);
        bclk_run = 1'b0;
        repeat (20) @(negedge clk);
        v = tx;
        repeat (100) begin
            @(negedge clk);
            if (tx !== v || bus.busy !== 1'b1) changes++;
        end
        n_cmp++; if (changes != 0) begin n_bad++; $display("FAIL stuck_hold: got %0d changed cycles want 0", changes); end
        bclk_run = 1'b1;
        wait_drain(600, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL stuck_resume: drained %b want 1", ok); end
        n_cmp++; if (rlog.size() != 1) begin n_bad++; $display("FAIL stuck_ready_count: got %0d want 1", rlog.size()); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_withdraw();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_bclk_stuck();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one 8N1 serial transmit line between NREQ on-chip requesters. Round-robin arbitration selects one byte, latches it, and serializes it LSB-first. Bit timing is paced by the rising edges of bclk, the divided baud clock from the baud generator (one bclk period per bit). Sits between the MIPS-side producers (CPU store port, debug/trace sources) and the physical uart_tx pin.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 8, bits per character (fixed 8 for 8N1; other values unsupported)
GID_W, 2, width of grant_id; must equal clog2(NREQ)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
bclk  in  1  baud clock from baud generator; a rising edge marks a bit boundary
req_valid  in  NREQ  bit i: requester i has a byte pending
req_data  in  NREQ*DATA_W  byte of requester i at [i*8+7 : i*8]
req_ready  out  NREQ  one-hot, single-cycle accept pulse to the granted requester
grant_id  out  GID_W  index of the requester currently or last granted
busy  out  1  high from grant until the end of the stop bit
tx  out  1  serial line, idle high

Behaviour:
- Reset: tx=1, busy=0, req_ready=0, grant_id=0, state=IDLE, bit counter=0, last-grant pointer=NREQ-1 (so requester 0 has first priority), bclk_q=1 (no spurious edge on the first cycle).
- Edge detect: bclk_q <= bclk every clk; bedge = bclk & ~bclk_q. All bit transitions occur on clk edges where bedge=1.
- States: IDLE, ARM, START, DATA, STOP.
- IDLE: if req_valid != 0, scan indices last+1, last+2, ... (mod NREQ) and take the first set bit, i. On that edge: shift_reg <= req_data[i]; grant_id <= i; last <= i; req_ready <= one-hot(i); busy <= 1; go to ARM. If no request, stay in IDLE with tx=1.
- req_ready is registered: high for exactly one cycle, the cycle after the arbitration edge; cleared on the next edge. Data is already captured by then, so the requester may drop or change valid/data during the ready cycle. A requester withdrawing valid before it is granted is legal and has no effect.
- ARM: wait for bedge; then tx <= 0 and go to START.
- START: on bedge, tx <= shift_reg[0], shift right, bitcnt <= 0, go to DATA.
- DATA: on bedge, if bitcnt==7 then tx <= 1 and go to STOP (or to PARITY when the optional feature is enabled); else tx <= next LSB and bitcnt <= bitcnt+1.
- STOP: on bedge, busy <= 0 and go to IDLE; tx stays 1. The stop bit therefore lasts exactly one bclk period.
- Frame on tx: start bit, D0..D7, stop bit; 10 bclk periods. The first start edge occurs 0 to 1 bclk periods after grant.
- Back-to-back frames: arbitration runs the clk cycle after leaving STOP, so consecutive frames are separated only by the ARM wait.
- Fairness: with all requesters valid, grants rotate 0,1,2,3,0,... No requester waits more than NREQ-1 frames.
- bclk stuck (no edges): FSM holds its state; tx holds its current value.
- rst mid-frame: frame aborts; tx=1 and busy=0 on the next cycle; the pointer returns to NREQ-1. The aborted byte is not retransmitted because its ready was already given.
- Grant is held for the whole frame; req_valid changes during a frame are ignored until IDLE.

Optional Feature:
UART_TX_PARITY_EN: when defined, adds a PARITY state between DATA and STOP. On leaving D7, tx <= even parity (XOR of the 8 data bits); the next bedge goes to STOP, which drives 1. Frame becomes 8E1, 11 bclk periods. When not defined, there is no PARITY state and the frame is 8N1, 10 periods.

Test Plan:
- Reset, then single request: bclk period 16 clk, req_valid=0001, req_data[7:0]=0x55 -> req_ready=0001 for 1 cycle; tx = 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each bit 16 clk; busy falls at the end of the stop bit.
- All four requesters valid with bytes 0xA0..0xA3, held until ready -> grant order 0,1,2,3; tx carries 0xA0,0xA1,0xA2,0xA3; exactly one req_ready pulse per requester.
- Fairness: requester 0 and requester 2 re-raise valid immediately after each accept, 6 frames -> grant_id sequence 0,2,0,2,0,2.
- Withdrawal: requester 1 raises valid during a frame, then drops it before the frame ends -> no grant to 1; tx stays idle high after the frame.
- Reset mid-frame: assert rst during D3 of 0xFF -> next cycle tx=1, busy=0, req_ready=0; the next request restarts with priority to requester 0.
- With UART_TX_PARITY_EN, send 0x07 -> 11-bit frame; parity bit = 1; stop bit = 1.
